// File: rtl/fitof.sv
// Three-stage pipelined int32 -> IEEE-754 single converter, round-to-nearest-even.
// Define ITOF_UNSIGNED_EN to add the is_unsigned input and the inexact output.
module fitof (
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic        stage1_valid,
    input  logic [31:0] x,
`ifdef ITOF_UNSIGNED_EN
    input  logic        is_unsigned,
`endif
    input  logic        stall,
    output logic [31:0] y,
    output logic        out_valid,
`ifdef ITOF_UNSIGNED_EN
    output logic        inexact,
`endif
    output logic        busy
);

    // Stage 1: sign / magnitude
    logic        treat_signed;
    logic        s1_sign_d;
    logic [31:0] s1_mag_d;
    logic        s1_valid_q;
    logic        s1_sign_q;
    logic [31:0] s1_mag_q;

`ifdef ITOF_UNSIGNED_EN
    assign treat_signed = ~is_unsigned;
`else
    assign treat_signed = 1'b1;
`endif

    assign s1_sign_d = treat_signed & x[31];
    // 0x80000000 negates to itself, which is the right unsigned magnitude
    assign s1_mag_d  = s1_sign_d ? (~x + 32'd1) : x;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= 32'd0;
        end else if (!stall) begin
            s1_valid_q <= stage1_valid;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
        end
    end

    // Stage 2: normalize
    logic [4:0]  lz;
    logic [31:0] norm;
    logic        s2_zero_d;
    logic [7:0]  s2_exp_d;
    logic        s2_valid_q;
    logic        s2_sign_q;
    logic        s2_zero_q;
    logic [7:0]  s2_exp_q;
    logic [30:0] s2_frac_q;

    always_comb begin
        lz = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (s1_mag_q[i]) begin
                lz = 5'(31 - i);
            end
        end
    end

    assign norm      = s1_mag_q << lz;
    assign s2_zero_d = (s1_mag_q == 32'd0);
    assign s2_exp_d  = 8'd158 - {3'b000, lz};

    // norm[31] is the implicit leading one and need not be stored
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_exp_q   <= 8'd0;
            s2_frac_q  <= 31'd0;
        end else if (!stall) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_zero_q  <= s2_zero_d;
            s2_exp_q   <= s2_exp_d;
            s2_frac_q  <= norm[30:0];
        end
    end

    // Stage 3: round / pack
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [30:0] packed_mag;
    logic [31:0] y_d;
    logic        inexact_d;
    logic [31:0] y_q;
    logic        out_valid_q;
    logic        inexact_q;

    assign mant       = s2_frac_q[30:8];
    assign guard      = s2_frac_q[7];
    assign sticky     = |s2_frac_q[6:0];
    assign round_up   = guard & (sticky | mant[0]);
    // Mantissa carry ripples into the exponent field; e never exceeds 159
    assign packed_mag = {s2_exp_q, mant} + {30'd0, round_up};
    assign y_d        = (s2_valid_q && !s2_zero_q) ? {s2_sign_q, packed_mag} : 32'd0;
    assign inexact_d  = s2_valid_q & (guard | sticky);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            y_q         <= 32'd0;
            inexact_q   <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= s2_valid_q;
            y_q         <= y_d;
            inexact_q   <= inexact_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign busy      = s1_valid_q | s2_valid_q | out_valid_q;

`ifdef ITOF_UNSIGNED_EN
    assign inexact = inexact_q;
`else
    logic unused_inexact;
    assign unused_inexact = inexact_q;
`endif

endmodule

// File: tb/tb_fitof.sv
// Self-checking bench for fitof: directed cases plus random traffic against a
// reference that converts through the simulator's double-precision arithmetic.
module tb_fitof;

    logic        sys_clk;
    logic        rstn;
    logic        stage1_valid;
    logic [31:0] x;
    logic        stall;
    logic [31:0] y;
    logic        out_valid;
    logic        busy;
    logic        inexact;
`ifdef ITOF_UNSIGNED_EN
    logic        is_unsigned;
`endif

    fitof dut (
        .sys_clk      (sys_clk),
        .rstn         (rstn),
        .stage1_valid (stage1_valid),
        .x            (x),
`ifdef ITOF_UNSIGNED_EN
        .is_unsigned  (is_unsigned),
        .inexact      (inexact),
`endif
        .stall        (stall),
        .y            (y),
        .out_valid    (out_valid),
        .busy         (busy)
    );

`ifndef ITOF_UNSIGNED_EN
    assign inexact = 1'b0;
`endif

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic [31:0] v;
        bit          uns;
        int          due;
    } op_t;

    op_t         q[$];
    int          adv;
    int          errors;
    int          checks;
    bit          model_ov;
    logic [31:0] prev_y;
    logic        prev_ov;
    logic        prev_inx;

    function automatic void chk(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    // Exact conversion to double, then RNE of the 52-bit fraction down to 23 bits
    function automatic logic [31:0] ref_cvt(input logic [31:0] v, input bit uns,
                                            output bit inx);
        real         r;
        logic [63:0] d;
        logic [10:0] de;
        logic [30:0] body;
        bit          g;
        bit          rest;
        if (v == 32'd0) begin
            inx = 1'b0;
            return 32'd0;
        end
        if (uns) r = real'(longint'({32'd0, v}));
        else     r = real'(int'($signed(v)));
        d    = $realtobits(r);
        de   = d[62:52] - 11'd896;
        body = {de[7:0], d[51:29]};
        g    = d[28];
        rest = |d[27:0];
        inx  = g | rest;
        if (g && (rest || d[29])) body = body + 31'd1;
        return {d[63], body};
    endfunction

    task automatic check_out(input bit st);
        logic [31:0] exp_y;
        bit          exp_inx;
        op_t         op;
        if (st) begin
            chk("hold_y", y, prev_y);
            chk("hold_valid", {31'd0, out_valid}, {31'd0, prev_ov});
            chk("hold_inexact", {31'd0, inexact}, {31'd0, prev_inx});
        end else begin
            model_ov = (q.size() > 0) && (q[0].due == adv);
            chk("out_valid", {31'd0, out_valid}, {31'd0, model_ov});
            if (model_ov) begin
                op    = q.pop_front();
                exp_y = ref_cvt(op.v, op.uns, exp_inx);
                chk("y", y, exp_y);
`ifdef ITOF_UNSIGNED_EN
                chk("inexact", {31'd0, inexact}, {31'd0, exp_inx});
`endif
            end else begin
                chk("y_idle", y, 32'd0);
            end
        end
        chk("busy", {31'd0, busy}, {31'd0, ((q.size() > 0) || model_ov)});
        prev_y   = y;
        prev_ov  = out_valid;
        prev_inx = inexact;
    endtask

    task automatic step(input bit v, input logic [31:0] xv, input bit st, input bit uns);
        op_t op;
        stage1_valid = v;
        x            = xv;
        stall        = st;
`ifdef ITOF_UNSIGNED_EN
        is_unsigned  = uns;
`endif
        @(posedge sys_clk);
        #1;
        if (!st) begin
            adv++;
            if (v) begin
                op.v   = xv;
                op.uns = uns;
                op.due = adv + 2;
                q.push_back(op);
            end
        end
        check_out(st);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("drained", q.size(), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    logic [31:0] basic[4];
    logic [31:0] rnd[4];

    initial begin
        errors       = 0;
        checks       = 0;
        adv          = 0;
        model_ov     = 1'b0;
        rstn         = 1'b0;
        stage1_valid = 1'b0;
        x            = 32'd0;
        stall        = 1'b0;
`ifdef ITOF_UNSIGNED_EN
        is_unsigned  = 1'b0;
`endif
        #12;
        chk("rst_y", y, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        prev_y   = 32'd0;
        prev_ov  = 1'b0;
        prev_inx = 1'b0;
        rstn     = 1'b1;

        // Basic values, then rounding corners, each issued back to back
        basic = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
        rnd   = '{32'd16777217, 32'd16777219, 32'd16777221, 32'h7FFF_FFFF};
        for (int i = 0; i < 4; i++) step(1'b1, basic[i], 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 4; i++) step(1'b1, rnd[i], 1'b0, 1'b0);
        drain();

        // 1..4 with a two-cycle stall after the second acceptance
        step(1'b1, 32'd1, 1'b0, 1'b0);
        step(1'b1, 32'd2, 1'b0, 1'b0);
        step(1'b1, 32'd3, 1'b1, 1'b0);
        step(1'b1, 32'd3, 1'b1, 1'b0);
        step(1'b1, 32'd3, 1'b0, 1'b0);
        step(1'b1, 32'd4, 1'b0, 1'b0);
        drain();

        // Operand presented only while stalled must never emerge
        step(1'b1, 32'd5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0, 1'b0);

`ifdef ITOF_UNSIGNED_EN
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step(1'b1, 32'h8000_0000, 1'b0, 1'b1);
        step(1'b1, 32'h8000_0000, 1'b0, 1'b0);
        drain();
`endif

        // Random traffic with random stalls
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rv;
            rv = $urandom();
            if ($urandom_range(0, 3) == 0) rv = rv >> $urandom_range(0, 31);
            step(($urandom_range(0, 3) != 0), rv, ($urandom_range(0, 4) == 0),
                 bit'($urandom_range(0, 1)) & bit'(`ifdef ITOF_UNSIGNED_EN 1 `else 0 `endif));
        end
        drain();

        // Asynchronous reset mid-cycle with three ops in flight
        for (int i = 0; i < 3; i++) step(1'b1, 32'd7 + i, 1'b0, 1'b0);
        stage1_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("amid_valid", {31'd0, out_valid}, 32'd0);
        chk("amid_busy", {31'd0, busy}, 32'd0);
        chk("amid_y", y, 32'd0);
        q.delete();
        model_ov = 1'b0;
        prev_y   = 32'd0;
        prev_ov  = 1'b0;
        prev_inx = 1'b0;
        rstn     = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fitof.md
Name: fitof

Overview:
- Pipelined converter from 32-bit two's-complement integer to IEEE-754 single precision.
- Round-to-nearest-even; the packing counterpart of the float field-decode/compare units.
- Sits in the FPU execute cluster beside the compare units.
- Uses the shared FPU valid-in/valid-out convention, plus a pipeline-wide stall for writeback backpressure.

Parameters:
- None. Latency fixed at 3 cycles; width fixed at 32.

Ports:
- sys_clk  input  1  single clock, rising edge
- rstn  input  1  asynchronous active-low reset
- stage1_valid  input  1  x is valid this cycle
- x  input  32  signed integer operand
- stall  input  1  hold entire pipeline; inputs ignored while high
- y  output  32  single-precision result
- out_valid  output  1  y valid this cycle
- busy  output  1  OR of all internal stage valid bits

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous and active-low on rstn.
- rstn low, asynchronously:
  - all stage valid bits and data registers clear to 0;
  - y=0, out_valid=0, busy=0.
  - In-flight operations are dropped with no partial output.
- Stage advance: all stage registers advance only when stall=0.
  - stall=1 freezes every register; y and out_valid hold their values.
  - Stall is all-or-nothing; there is no bubble collapsing.
- Latency: an operand accepted at edge N (stage1_valid=1, stall=0) appears on y with out_valid=1 after edge N+2.
  - y and out_valid are driven directly from stage-3 registers.
  - Throughput is 1 operand per non-stalled cycle.
- Stage 1 (sign/magnitude):
  - s = x[31]; mag = s ? -x : x as 32-bit unsigned.
  - 0x80000000 yields mag=0x80000000, which is correct as unsigned.
  - Registers s, mag, valid.
- Stage 2 (normalize):
  - lz = leading-zero count of mag (0..31; mag=0 flagged as zero).
  - norm = mag << lz, so norm[31]=1 unless zero.
  - Registers s, zero flag, e = 158 - lz (8 bits), norm[31:0], valid.
- Stage 3 (round/pack):
  - mant = norm[30:8]; G = norm[7]; R|S = |norm[6:0].
  - Round up iff G & (R|S | mant[0]).
  - On round-up, {e,mant} is incremented as a 31-bit quantity, so a mantissa carry bumps the exponent. Example: 0x7FFFFFFF gives 0x4F000000.
  - Exponent overflow is impossible (max e=158, max after carry 159).
  - Zero input gives y=0x00000000; -0 is never produced.
- Invalid ops: when a stage valid bit is 0, its data registers may hold stale values.
  - Exception: y is forced to 0 when out_valid=0 after a stage-3 update with no valid op.
- busy: combinational OR of the stage-1, stage-2 and stage-3 valid bits.
- stage1_valid while stall=1: not captured. The producer must hold or re-present the operand.
- Stall released mid-stream: resumes with no loss or duplication. Each accepted op produces exactly one out_valid pulse-cycle per non-stalled advance, and holds while stalled.
- Rounding: only round-to-nearest-even; no rounding-mode input.
- Exceptions: no exception flags, except as listed under Optional Feature.

Optional Feature:
- Macro: ITOF_UNSIGNED_EN.
- When defined:
  - Adds input port is_unsigned (1 bit), sampled with x at stage 1.
  - When is_unsigned=1: s=0 and mag=x with no negation. Example: 0xFFFFFFFF yields 2^32 = 0x4F800000, with e reaching 159 via rounding carry.
  - Adds output inexact (1 bit), registered at stage 3 alongside y: inexact = G|R|S for the valid op, else 0.
- When undefined: neither port exists; conversion is always signed.

Test Plan:
- Reset mid-stream: drive valid ops on 3 consecutive cycles, assert rstn=0 asynchronously mid-cycle -> out_valid, busy, y are 0 immediately; no output appears after rstn is released.
- Basic values, stall=0 -> each y appears exactly 3 edges after acceptance:
  - 0 -> 0x00000000
  - 1 -> 0x3F800000
  - -1 -> 0xBF800000
  - 0x80000000 -> 0xCF000000
- Rounding:
  - 16777217 -> 0x4B800000 (tie to even, down)
  - 16777219 -> 0x4B800002 (tie to even, up)
  - 16777221 -> 0x4B800002 (tie, mantissa already even, down)
  - 0x7FFFFFFF -> 0x4F000000 (carry into exponent)
- Back-to-back with stall:
  - Inputs 1, 2, 3, 4 on consecutive cycles; stall=1 for 2 cycles after the 2nd acceptance.
  - -> Outputs 0x3F800000, 0x40000000, 0x40400000, 0x40800000 in order, none lost or duplicated.
  - y/out_valid hold during stall; busy=1 throughout, then 0 after drain.
- Input ignored during stall: stage1_valid=1, x=5 while stall=1, then stall=0 with stage1_valid=0 -> no 0x40A00000 ever output.
- ITOF_UNSIGNED_EN:
  - is_unsigned=1: 0xFFFFFFFF -> 0x4F800000, inexact=1.
  - is_unsigned=1: 0x80000000 -> 0x4F000000, inexact=0.
  - is_unsigned=0: 0x80000000 -> 0xCF000000.
